// File: rtl/sobel_pkg.sv
// Shared constants and FSM state type for the Sobel window front-end.
package sobel_pkg;

    localparam int PIX_W  = 8;
    localparam int WIN_W  = 72;
    localparam int LB_NUM = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RD   = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/sobel_line_buf.sv
// One image line: single write port, combinational 3-pixel read starting at rd_col.
// Columns at or beyond IMG_W (including a wrapped "negative" rd_col) read as zero.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int IMG_W = 512,
    localparam int COL_W = $clog2(IMG_W),
    localparam int PTR_W = COL_W + 1
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [COL_W-1:0]   wr_col,
    input  logic [PIX_W-1:0]   wr_data,
    input  logic [PTR_W-1:0]   rd_col,
    output logic [3*PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem [IMG_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_col] <= wr_data;
        end
    end

    // rd_col is one bit wider than a column index so that rd_ptr-1 at column 0
    // wraps to a large value and falls into the zero-fill range.
    for (genvar gi = 0; gi < 3; gi++) begin : g_tap
        logic [PTR_W-1:0] col;
        assign col = rd_col + PTR_W'(gi);
        assign rd_data[gi*PIX_W +: PIX_W] =
            (col < PTR_W'(IMG_W)) ? mem[col[COL_W-1:0]] : '0;
    end

endmodule

// File: rtl/sobel_win_ctrl.sv
// Sobel 3x3 window sequencer over four rotating line buffers.
// Optional macro SOBEL_WIN_CTRL_ZERO_PAD_EN: IMG_W centred windows per row with zero padding.
module sobel_win_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W = 512,
    parameter int CNT_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [PIX_W-1:0] i_pixel_data,
    input  logic             i_pixel_data_valid,
    output logic [WIN_W-1:0] o_pixel_data,
    output logic             o_pixel_data_valid,
    output logic             o_intr,
    output logic             o_overflow
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int PTR_W = COL_W + 1;
`ifdef SOBEL_WIN_CTRL_ZERO_PAD_EN
    localparam int N_WIN = IMG_W;
`else
    localparam int N_WIN = IMG_W - 2;
`endif
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(4 * IMG_W);
    localparam logic [CNT_W-1:0] CNT_RD   = CNT_W'(3 * IMG_W);
    localparam logic [CNT_W-1:0] CNT_ROW  = CNT_W'(IMG_W);

    ctrl_state_t      state_reg, state_next;
    logic [1:0]       wr_sel_reg, rd_sel_reg;
    logic [COL_W-1:0] wr_col_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [WIN_W-1:0] win_reg;
    logic             valid_reg, intr_reg, ovf_reg;

    logic             rd_en, row_end, full, accept;
    logic [PTR_W-1:0] rd_col;
    logic [WIN_W-1:0] win;
    logic [3*PIX_W-1:0] lb_data [LB_NUM];

    assign full   = (count_reg == CNT_FULL);
    assign accept = i_pixel_data_valid && !full;

    always_comb begin
        state_next = state_reg;
        rd_en      = 1'b0;
        row_end    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg >= CNT_RD) begin
                    state_next = RD;
                end
            end
            RD: begin
                rd_en = 1'b1;
                if (rd_ptr_reg == COL_W'(N_WIN - 1)) begin
                    row_end    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign count_next = count_reg + CNT_W'(accept) - (row_end ? CNT_ROW : '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg  <= IDLE;
            wr_sel_reg <= '0;
            wr_col_reg <= '0;
            rd_sel_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (accept) begin
                if (wr_col_reg == COL_W'(IMG_W - 1)) begin
                    wr_col_reg <= '0;
                    wr_sel_reg <= wr_sel_reg + 2'd1;
                end else begin
                    wr_col_reg <= wr_col_reg + COL_W'(1);
                end
            end
            if (rd_en) begin
                if (row_end) begin
                    rd_ptr_reg <= '0;
                    rd_sel_reg <= rd_sel_reg + 2'd1;
                end else begin
                    rd_ptr_reg <= rd_ptr_reg + COL_W'(1);
                end
            end
        end
    end

`ifdef SOBEL_WIN_CTRL_ZERO_PAD_EN
    assign rd_col = PTR_W'(rd_ptr_reg) - PTR_W'(1);
`else
    assign rd_col = PTR_W'(rd_ptr_reg);
`endif

    for (genvar gi = 0; gi < LB_NUM; gi++) begin : g_lb
        sobel_line_buf #(.IMG_W(IMG_W)) u_lb (
            .clk     (i_clk),
            .wr_en   (accept && (wr_sel_reg == 2'(gi))),
            .wr_col  (wr_col_reg),
            .wr_data (i_pixel_data),
            .rd_col  (rd_col),
            .rd_data (lb_data[gi])
        );
    end

    // Line k of the window is buffer rd_sel+k; k=0 is the oldest (top) line.
    for (genvar gi = 0; gi < 3; gi++) begin : g_win
        assign win[gi*3*PIX_W +: 3*PIX_W] = lb_data[rd_sel_reg + 2'(gi)];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            win_reg   <= '0;
            valid_reg <= 1'b0;
            intr_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            valid_reg <= rd_en;
            intr_reg  <= row_end;
            if (rd_en) begin
                win_reg <= win;
            end
            if (i_pixel_data_valid && full) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign o_pixel_data       = win_reg;
    assign o_pixel_data_valid = valid_reg;
    assign o_intr             = intr_reg;
    assign o_overflow         = ovf_reg;

endmodule

// File: tb/tb_sobel_win_ctrl.sv
// Scoreboard bench for sobel_win_ctrl at IMG_W=8; follows SOBEL_WIN_CTRL_ZERO_PAD_EN when defined.
module tb_sobel_win_ctrl;

    localparam int IMG_W = 8;
`ifdef SOBEL_WIN_CTRL_ZERO_PAD_EN
    localparam bit PAD  = 1'b1;
    localparam int NWIN = IMG_W;
    localparam logic [71:0] FIRST_WIN = 72'h212000_111000_010000;
    localparam logic [71:0] LAST_WIN  = 72'h002726_001716_000706;
`else
    localparam bit PAD  = 1'b0;
    localparam int NWIN = IMG_W - 2;
    localparam logic [71:0] FIRST_WIN = 72'h222120_121110_020100;
    localparam logic [71:0] LAST_WIN  = 72'h272625_171615_070605;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pix_data = 8'h00;
    logic        pix_valid = 1'b0;
    logic [71:0] win_out;
    logic        win_valid, intr, ovf;

    typedef struct packed {
        logic [71:0] win;
        logic        last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int total = 0, bad = 0;
    int win_cnt = 0, intr_cnt = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
    int first_wr = 0, wr_total = 0;
    logic [71:0] first_win, last_win;

    sobel_win_ctrl #(.IMG_W(IMG_W), .CNT_W(12)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_pixel_data       (pix_data),
        .i_pixel_data_valid (pix_valid),
        .o_pixel_data       (win_out),
        .o_pixel_data_valid (win_valid),
        .o_intr             (intr),
        .o_overflow         (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'(r * 16 + c);
    endfunction

    task automatic push_row(input int r);
        for (int w = 0; w < NWIN; w++) begin
            exp_t e;
            e.win  = '0;
            e.last = (w == NWIN - 1);
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 3; j++) begin
                    int col;
                    col = PAD ? (w - 1 + j) : (w + j);
                    if (col >= 0 && col < IMG_W) e.win[k*24 + j*8 +: 8] = pix(r + k, col);
                end
            end
            sb.push_back(e);
        end
    endtask

    // One line per window transaction.
    always @(negedge clk) begin
        if (rst_n) begin
            if (win_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got win=%h intr=%b, required no window", win_out, intr);
                end else begin
                    mon_e = sb.pop_front();
                    if (win_out !== mon_e.win || intr !== mon_e.last) begin
                        bad++;
                        $display("FAIL sb_window: got win=%h intr=%b, required win=%h intr=%b",
                                 win_out, intr, mon_e.win, mon_e.last);
                    end else begin
                        $display("win %0d: %h intr=%b ok", win_cnt, win_out, intr);
                    end
                end
                if (win_cnt == 0) begin
                    first_cyc = cyc;
                    first_win = win_out;
                    first_wr  = wr_total;
                end
                last_cyc = cyc;
                last_win = win_out;
                win_cnt++;
            end else if (intr) begin
                total++;
                bad++;
                $display("FAIL intr_alone: got intr=1 without valid, required 0");
            end
            if (intr) intr_cnt++;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        pix_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        win_cnt = 0;
        intr_cnt = 0;
        wr_total = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int nrows, input bit gaps);
        for (int p = 0; p < nrows * IMG_W; p++) begin
            int r, c;
            r = p / IMG_W;
            c = p % IMG_W;
            pix_valid = 1'b1;
            pix_data  = pix(r, c);
            if (c == IMG_W - 1 && r >= 2) push_row(r - 2);
            @(posedge clk);
            #1;
            wr_total++;
            if (gaps) begin
                pix_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d windows outstanding, required 0", tag, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        total += 4;
        if (win_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", win_valid); end
        if (intr !== 1'b0) begin bad++; $display("FAIL reset_intr: got %b, required 0", intr); end
        if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
        if (win_out !== 72'h0) begin bad++; $display("FAIL reset_data: got %h, required 0", win_out); end
        $display("reset checked");
    endtask

    task automatic test_fill();
        do_reset();
        stream(3, 1'b0);
        total += 4;
        if (win_valid !== 1'b0) begin bad++; $display("FAIL fill_lat0: got valid=%b, required 0", win_valid); end
        @(posedge clk);
        #1;
        if (win_valid !== 1'b0) begin bad++; $display("FAIL fill_lat1: got valid=%b, required 0", win_valid); end
        @(posedge clk);
        #1;
        if (win_valid !== 1'b1) begin bad++; $display("FAIL fill_lat2: got valid=%b, required 1", win_valid); end
        if (win_out !== FIRST_WIN) begin bad++; $display("FAIL fill_first: got %h, required %h", win_out, FIRST_WIN); end
        wait_drain("fill");
        total += 6;
        if (win_cnt != NWIN) begin bad++; $display("FAIL row_count: got %0d, required %0d", win_cnt, NWIN); end
        if (last_cyc - first_cyc + 1 != NWIN) begin
            bad++; $display("FAIL row_consec: got span %0d, required %0d", last_cyc - first_cyc + 1, NWIN);
        end
        if (last_win !== LAST_WIN) begin bad++; $display("FAIL row_last: got %h, required %h", last_win, LAST_WIN); end
        if (intr_cnt != 1) begin bad++; $display("FAIL row_intr: got %0d pulses, required 1", intr_cnt); end
        if (dut.count_reg !== 12'd16) begin bad++; $display("FAIL row_count_reg: got %0d, required 16", dut.count_reg); end
        if (ovf !== 1'b0) begin bad++; $display("FAIL fill_ovf: got %b, required 0", ovf); end
        $display("fill/row scenario: %0d windows", win_cnt);
    endtask

    task automatic test_wrap();
        do_reset();
        stream(6, 1'b0);
        wait_drain("wrap");
        total += 3;
        if (win_cnt != 4 * NWIN) begin bad++; $display("FAIL wrap_count: got %0d, required %0d", win_cnt, 4 * NWIN); end
        if (intr_cnt != 4) begin bad++; $display("FAIL wrap_intr: got %0d, required 4", intr_cnt); end
        if (ovf !== 1'b0) begin bad++; $display("FAIL wrap_ovf: got %b, required 0", ovf); end
        $display("wrap scenario: %0d windows", win_cnt);
    endtask

    task automatic test_gaps();
        do_reset();
        stream(3, 1'b1);
        wait_drain("gaps");
        total += 4;
        if (win_cnt != NWIN) begin bad++; $display("FAIL gaps_count: got %0d, required %0d", win_cnt, NWIN); end
        if (first_wr < 3 * IMG_W) begin bad++; $display("FAIL gaps_early: got first window after %0d writes, required >= %0d", first_wr, 3 * IMG_W); end
        if (first_win !== FIRST_WIN) begin bad++; $display("FAIL gaps_first: got %h, required %h", first_win, FIRST_WIN); end
        if (intr_cnt != 1) begin bad++; $display("FAIL gaps_intr: got %0d, required 1", intr_cnt); end
        $display("gaps scenario: %0d windows", win_cnt);
    endtask

    task automatic test_reset_mid_row();
        do_reset();
        stream(3, 1'b0);
        for (int i = 0; i < 10 && !win_valid; i++) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (win_valid !== 1'b1) begin bad++; $display("FAIL mid_reach_rd: got valid=%b, required 1", win_valid); end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total += 3;
        if (win_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b, required 0", win_valid); end
        if (intr !== 1'b0) begin bad++; $display("FAIL mid_intr: got %b, required 0", intr); end
        if (ovf !== 1'b0) begin bad++; $display("FAIL mid_ovf: got %b, required 0", ovf); end
        sb.delete();
        $display("mid-row reset checked");
        repeat (2) @(posedge clk);
        test_fill();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_gaps();
        test_reset_mid_row();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
